// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// wrong-path flush, register-file write-through and performance counters.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   hold              global freeze: every register and counter keeps its value
//   ex_flush          taken branch/jump in EX; the ID instruction is wrong-path
//   id_*              decoded instruction presented by the ID stage
//   wb_*              register-file write happening this cycle
//   ex_*              registered EX-stage instruction (to forwarding unit / ALU)
//   stall_front       combinational; freezes PC and IF/ID on a load-use hazard
//   bubble_cnt        bubbles inserted for load-use hazards (wraps)
//   flush_cnt         valid ID instructions squashed by ex_flush (wraps)
module id_ex_stage #(
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ex_flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1_idx,
  input  logic [4:0]        id_rs2_idx,
  input  logic [4:0]        id_rd_idx,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd_idx,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rs1_idx,
  output logic [4:0]        ex_rs2_idx,
  output logic [4:0]        ex_rd_idx,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic              stall_front,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1_idx;
    logic [4:0]        rs2_idx;
    logic [4:0]        rd_idx;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
  } ex_t;

  ex_t         ex_q;
  ex_t         cap;
  logic        load_use;
  logic [31:0] bubble_q;
  logic [31:0] flush_q;

  // A load in EX whose destination the ID instruction reads: its data is not
  // available until MEM, so one bubble is needed. x0 never creates a hazard.
  assign load_use = ex_q.valid && ex_q.ctrl[1] && (ex_q.rd_idx != 5'd0) &&
                    id_valid && ((id_rs1_idx == ex_q.rd_idx) ||
                                 (id_rs2_idx == ex_q.rd_idx));

  // A flush squashes the ID instruction anyway, so holding it would be wrong.
  assign stall_front = load_use && !ex_flush && !rst;

  // Capture image. The register file is read in ID before this cycle's WB
  // write lands, so the WB value is forwarded here.
  always_comb begin
    cap          = '0;
    cap.valid    = id_valid;
    cap.pc       = id_pc;
    cap.imm      = id_imm;
    cap.ctrl     = id_ctrl;
    cap.ctrl[0]  = id_ctrl[0] && id_valid && (id_rd_idx != 5'd0);
    cap.rs1_idx  = id_rs1_idx;
    cap.rs2_idx  = id_rs2_idx;
    cap.rd_idx   = id_rd_idx;
    cap.rs1_data = (wb_regwrite && (wb_rd_idx != 5'd0) && (wb_rd_idx == id_rs1_idx))
                   ? wb_data : id_rs1_data;
    cap.rs2_data = (wb_regwrite && (wb_rd_idx != 5'd0) && (wb_rd_idx == id_rs2_idx))
                   ? wb_data : id_rs2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else if (hold) begin
      ex_q     <= ex_q;
    end else if (ex_flush) begin
      ex_q     <= '0;
      if (id_valid) flush_q <= flush_q + 32'd1;
    end else if (load_use) begin
      ex_q     <= '0;
      bubble_q <= bubble_q + 32'd1;
    end else begin
      ex_q     <= cap;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_imm      = ex_q.imm;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_rs1_idx  = ex_q.rs1_idx;
  assign ex_rs2_idx  = ex_q.rs2_idx;
  assign ex_rd_idx   = ex_q.rd_idx;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign bubble_cnt  = bubble_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage. The stimulus process
// pushes, per cycle, the expected stall_front for the inputs it applies and
// the expected EX register/counter state after the next rising edge. The
// monitor process checks stall_front mid-cycle and the registered state just
// after the edge, popping one record per cycle.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, hold, ex_flush;
  logic        id_valid;
  logic [31:0] id_pc, id_imm;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        wb_regwrite;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [11:0] ex_ctrl;
  logic [4:0]  ex_rs1_idx, ex_rs2_idx, ex_rd_idx;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic        stall_front;
  logic [31:0] bubble_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(12)) dut (
    .clk(clk), .rst(rst), .hold(hold), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .wb_regwrite(wb_regwrite), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx), .ex_rd_idx(ex_rd_idx),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .stall_front(stall_front), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        stall;
    logic        v;
    logic [31:0] pc, imm;
    logic [11:0] ctrl;
    logic [4:0]  r1, r2, rd;
    logic [31:0] d1, d2, bc, fc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t cap(input logic st, input logic v, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [11:0] ctrl,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] bc,
                               input logic [31:0] fc);
    exp_t e;
    e.stall = st; e.v = v; e.pc = pc; e.imm = imm; e.ctrl = ctrl;
    e.r1 = r1; e.r2 = r2; e.rd = rd; e.d1 = d1; e.d2 = d2; e.bc = bc; e.fc = fc;
    return e;
  endfunction

  function automatic exp_t bub(input logic st, input logic [31:0] bc, input logic [31:0] fc);
    return cap(st, 1'b0, 32'd0, 32'd0, 12'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, bc, fc);
  endfunction

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [11:0] ctrl, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_pc = pc; id_imm = imm; id_ctrl = ctrl;
    id_rs1_idx = r1; id_rs2_idx = r2; id_rd_idx = rd;
    id_rs1_data = d1; id_rs2_data = d2;
  endtask

  // Issue one cycle: record expectation, then advance past the edge.
  task automatic cyc(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t got;
    bit   have;
    int   rec = 0;
    forever begin
      @(negedge clk);
      have = (sb.size() > 0);
      if (have) begin
        checks++;
        if (stall_front !== sb[0].stall) begin
          failures++;
          $display("FAIL stall_front rec %0d: got %b exp %b", rec, stall_front, sb[0].stall);
        end
      end
      @(posedge clk);
      #2;
      if (have) begin
        e = sb.pop_front();
        got = cap(e.stall, ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1_idx, ex_rs2_idx,
                  ex_rd_idx, ex_rs1_data, ex_rs2_data, bubble_cnt, flush_cnt);
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL ex_state rec %0d: got v=%b pc=%h imm=%h ctrl=%h r1=%0d r2=%0d rd=%0d d1=%h d2=%h bc=%0d fc=%0d exp v=%b pc=%h imm=%h ctrl=%h r1=%0d r2=%0d rd=%0d d1=%h d2=%h bc=%0d fc=%0d",
                   rec, got.v, got.pc, got.imm, got.ctrl, got.r1, got.r2, got.rd, got.d1, got.d2, got.bc, got.fc,
                   e.v, e.pc, e.imm, e.ctrl, e.r1, e.r2, e.rd, e.d1, e.d2, e.bc, e.fc);
        end
        rec++;
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; hold = 1'b0; ex_flush = 1'b0;
    wb_regwrite = 1'b0; wb_rd_idx = 5'd0; wb_data = 32'd0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // reset state
    cyc(bub(0, 0, 0));
    cyc(bub(0, 0, 0));
    rst = 1'b0;
    // normal capture, one-cycle latency
    id_set(1, 32'h100, 32'h10, 12'h001, 1, 2, 5, 32'h11, 32'h22);
    cyc(cap(0, 1, 32'h100, 32'h10, 12'h001, 1, 2, 5, 32'h11, 32'h22, 0, 0));
    // lw x5 into EX
    id_set(1, 32'h104, 32'h4, 12'h003, 2, 0, 5, 32'h1000, 0);
    cyc(cap(0, 1, 32'h104, 32'h4, 12'h003, 2, 0, 5, 32'h1000, 0, 0, 0));
    // add uses x5 on rs1: one-cycle load-use stall, then captured
    id_set(1, 32'h108, 0, 12'h001, 5, 6, 7, 0, 32'h66);
    cyc(bub(1, 1, 0));
    cyc(cap(0, 1, 32'h108, 0, 12'h001, 5, 6, 7, 0, 32'h66, 1, 0));
    // lw x9, then flush while ID uses x9: flush wins, no stall
    id_set(1, 32'h10C, 32'h8, 12'h003, 1, 0, 9, 32'h20, 0);
    cyc(cap(0, 1, 32'h10C, 32'h8, 12'h003, 1, 0, 9, 32'h20, 0, 1, 0));
    ex_flush = 1'b1;
    id_set(1, 32'h110, 0, 12'h001, 3, 9, 4, 3, 9);
    cyc(bub(0, 1, 1));
    ex_flush = 1'b0;
    // WB write-through on rs2
    wb_regwrite = 1'b1; wb_rd_idx = 5'd3; wb_data = 32'hDEADBEEF;
    id_set(1, 32'h200, 0, 12'h001, 1, 3, 8, 5, 0);
    cyc(cap(0, 1, 32'h200, 0, 12'h001, 1, 3, 8, 5, 32'hDEADBEEF, 1, 1));
    // WB to x0 never forwards, even onto an x0 source
    wb_rd_idx = 5'd0;
    id_set(1, 32'h204, 0, 12'h001, 1, 0, 8, 5, 0);
    cyc(cap(0, 1, 32'h204, 0, 12'h001, 1, 0, 8, 5, 0, 1, 1));
    // write-through on rs1
    wb_rd_idx = 5'd1;
    id_set(1, 32'h208, 0, 12'h001, 1, 3, 8, 5, 32'h33);
    cyc(cap(0, 1, 32'h208, 0, 12'h001, 1, 3, 8, 32'hDEADBEEF, 32'h33, 1, 1));
    // matching index but no write
    wb_regwrite = 1'b0;
    id_set(1, 32'h20C, 0, 12'h001, 1, 3, 8, 5, 32'h33);
    cyc(cap(0, 1, 32'h20C, 0, 12'h001, 1, 3, 8, 5, 32'h33, 1, 1));
    // load to x0: RegWrite bit cleared
    id_set(1, 32'h300, 0, 12'h003, 2, 0, 0, 32'h40, 0);
    cyc(cap(0, 1, 32'h300, 0, 12'h002, 2, 0, 0, 32'h40, 0, 1, 1));
    // use of x0 after load to x0: no stall
    id_set(1, 32'h304, 0, 12'h001, 0, 0, 6, 0, 0);
    cyc(cap(0, 1, 32'h304, 0, 12'h001, 0, 0, 6, 0, 0, 1, 1));
    // invalid ID instruction: RegWrite bit cleared, ex_valid=0
    id_set(0, 32'h308, 0, 12'h005, 1, 2, 7, 1, 2);
    cyc(cap(0, 0, 32'h308, 0, 12'h004, 1, 2, 7, 1, 2, 1, 1));
    // flush of an invalid instruction does not count
    ex_flush = 1'b1;
    cyc(bub(0, 1, 1));
    ex_flush = 1'b0;
    // lw x5, then hold 3 cycles with a dependent, changing ID
    id_set(1, 32'h400, 0, 12'h003, 1, 0, 5, 7, 0);
    cyc(cap(0, 1, 32'h400, 0, 12'h003, 1, 0, 5, 7, 0, 1, 1));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_flush = (i == 2);
      id_set(1, 32'h404 + 32'(4 * i), 32'(i), 12'h001, 5, 5'(i), 5'(10 + i), 32'(i), 32'(i));
      cyc(cap((i != 2), 1, 32'h400, 0, 12'h003, 1, 0, 5, 7, 0, 1, 1));
    end
    ex_flush = 1'b0;
    // reset wins over hold
    rst = 1'b1;
    id_set(1, 32'h410, 0, 12'h001, 5, 0, 3, 0, 0);
    cyc(bub(0, 0, 0));
    rst = 1'b0; hold = 1'b0;
    // reset mid-stall leaves no residual stall
    id_set(1, 32'h500, 0, 12'h003, 1, 0, 5, 7, 0);
    cyc(cap(0, 1, 32'h500, 0, 12'h003, 1, 0, 5, 7, 0, 0, 0));
    rst = 1'b1;
    id_set(1, 32'h504, 0, 12'h001, 5, 2, 6, 1, 2);
    cyc(bub(0, 0, 0));
    rst = 1'b0;
    cyc(cap(0, 1, 32'h504, 0, 12'h001, 5, 2, 6, 1, 2, 0, 0));
    // load-use through rs2
    id_set(1, 32'h600, 0, 12'h003, 1, 0, 7, 8, 0);
    cyc(cap(0, 1, 32'h600, 0, 12'h003, 1, 0, 7, 8, 0, 0, 0));
    id_set(1, 32'h604, 0, 12'h001, 2, 7, 9, 2, 3);
    cyc(bub(1, 1, 0));
    cyc(cap(0, 1, 32'h604, 0, 12'h001, 2, 7, 9, 2, 3, 1, 0));
    // idle
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(cap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d records left, exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
